alu2_arbiter: RTL and testbench

ALU2_ARBITER -- requirements
Module: alu2_arbiter

---
 rtl/alu2_arbiter.sv | 106 ++++++++++
 tb/tb_alu2_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu2_arbiter.sv
// alu2_arbiter: two requesters share one ALU through a round-robin arbiter.
// The single result register is drained by a valid/ready consumer.
//
// state | meaning
// ------+-------------------------------------------------------------
// EMPTY | result register holds nothing; rsp_valid = 0
// FULL  | result register holds an unconsumed result; rsp_valid = 1
module alu2_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_c,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_c,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_f,
    output logic             rsp_id
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state;
    logic             last_grant;
    logic             can_accept;
    logic             grant0;
    logic             grant1;
    logic             accept;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [1:0]       op_c;
    logic [WIDTH-1:0] alu_f;

    assign rsp_valid = (state == FULL);

    // Readys are suppressed during reset so nothing presented then is taken.
    assign can_accept = (~rsp_valid | rsp_ready) & ~rst;

    // Round-robin grant: a tie goes to the requester that did not win last.
    always_comb begin
        grant0 = req0_valid & (~req1_valid | last_grant);
        grant1 = req1_valid & (~req0_valid | ~last_grant);
    end

    assign req0_ready = can_accept & grant0;
    assign req1_ready = can_accept & grant1;
    assign accept     = req0_ready | req1_ready;

    // Operand mux in front of the one shared ALU.
    always_comb begin
        op_a = grant1 ? req1_a : req0_a;
        op_b = grant1 ? req1_b : req0_b;
        op_c = grant1 ? req1_c : req0_c;
    end

    // Shared ALU; carries out of the top bit are dropped.
    always_comb begin
        alu_f = '0;
        case (op_c)
            2'b00:   alu_f = op_a + op_b;
            2'b01:   alu_f = op_a + op_b + WIDTH'(1);
            2'b10:   alu_f = op_a & op_b;
            default: alu_f = op_a ^ op_b;
        endcase
    end

    // Result register and state: a new acceptance overwrites in the same
    // cycle the old result is consumed, so back-to-back ops see no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            rsp_f      <= '0;
            rsp_id     <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state      <= FULL;
                        rsp_f      <= alu_f;
                        rsp_id     <= grant1;
                        last_grant <= grant1;
                    end
                end
                default: begin
                    if (accept) begin
                        rsp_f      <= alu_f;
                        rsp_id     <= grant1;
                        last_grant <= grant1;
                    end else if (rsp_ready) begin
                        state <= EMPTY;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu2_arbiter.sv
// Directed bench for alu2_arbiter, followed by an exhaustive operand sweep
// and a randomized run checked against a small reference model.
module tb_alu2_arbiter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready;
    logic [W-1:0] req0_a, req0_b;
    logic [1:0]   req0_c;
    logic         req1_valid, req1_ready;
    logic [W-1:0] req1_a, req1_b;
    logic [1:0]   req1_c;
    logic         rsp_valid, rsp_ready;
    logic [W-1:0] rsp_f;
    logic         rsp_id;

    int tests = 0;
    int fails = 0;

    alu2_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_c(req0_c),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_c(req1_c),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_f(rsp_f), .rsp_id(rsp_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [1:0] c);
        logic [W:0] s;
        case (c)
            2'b00:   s = {1'b0, a} + {1'b0, b};
            2'b01:   s = {1'b0, a} + {1'b0, b} + 1;
            2'b10:   s = {1'b0, a & b};
            default: s = {1'b0, a ^ b};
        endcase
        return s[W-1:0];
    endfunction

    task automatic chk_rsp(input string tag, input logic v, input logic [W-1:0] f, input logic id);
        chk({tag, "_valid"}, rsp_valid, v);
        chk({tag, "_f"}, rsp_f, f);
        chk({tag, "_id"}, rsp_id, id);
    endtask

    task automatic chk_rdy(input string tag, input logic r0, input logic r1);
        chk({tag, "_rdy0"}, req0_ready, r0);
        chk({tag, "_rdy1"}, req1_ready, r1);
    endtask

    initial begin
        logic         m_full, m_last, m_id, e0, e1, g0, g1, can, acc0, acc1;
        logic [W-1:0] m_f;
        logic [9:0]   k;

        // reset held two cycles with both requesters valid
        rst = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 4'h7; req0_b = 4'h9; req0_c = 2'b00;
        req1_valid = 1'b1; req1_a = 4'hA; req1_b = 4'h6; req1_c = 2'b11;
        #1;
        chk_rdy("rst_pre", 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_rsp("rst", 1'b0, 4'h0, 1'b0);
            chk_rdy("rst", 1'b0, 1'b0);
        end

        // first tie after reset goes to requester 0; 7+9 wraps to 0
        rst = 1'b0;
        #1;
        chk_rdy("first_tie", 1'b1, 1'b0);
        tick();
        chk_rsp("wrap_add", 1'b1, 4'h0, 1'b0);
        #1;
        chk_rdy("alt1", 1'b0, 1'b1);
        tick();
        chk_rsp("xor_r1", 1'b1, 4'hC, 1'b1);

        // add-with-carry-in also wraps: 7+9+1 = 1
        req1_valid = 1'b0; req0_c = 2'b01;
        #1;
        chk_rdy("addc", 1'b1, 1'b0);
        tick();
        chk_rsp("addc", 1'b1, 4'h1, 1'b0);

        // consumer drains with no new request -> empty
        req0_valid = 1'b0;
        tick();
        chk("drain_valid", rsp_valid, 1'b0);

        // single req1 op so the next tie favours requester 0
        req1_valid = 1'b1; req1_a = 4'h5; req1_b = 4'h5; req1_c = 2'b10;
        tick();
        chk_rsp("and_r1", 1'b1, 4'h5, 1'b1);

        // continuous dual requests alternate 0,1,0,1 with no bubble
        req0_valid = 1'b1; req0_a = 4'h3; req0_b = 4'h4; req0_c = 2'b01;
        req1_valid = 1'b1; req1_a = 4'hA; req1_b = 4'h6; req1_c = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk_rdy("rr", (i % 2) == 0, (i % 2) == 1);
            tick();
            if (i % 2 == 0) chk_rsp("rr", 1'b1, 4'h8, 1'b0);
            else            chk_rsp("rr", 1'b1, 4'hC, 1'b1);
        end

        // backpressure: result held, no acceptance, for 3 cycles
        rsp_ready = 1'b0; req0_valid = 1'b0;
        req1_a = 4'hC; req1_b = 4'hA; req1_c = 2'b10;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_rdy("stall", 1'b0, 1'b0);
            tick();
            chk_rsp("stall", 1'b1, 4'hC, 1'b1);
        end
        rsp_ready = 1'b1;
        #1;
        chk_rdy("unstall", 1'b0, 1'b1);
        tick();
        chk_rsp("unstall", 1'b1, 4'h8, 1'b1);

        // reset while a result is pending discards it
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 4'h2; req0_b = 4'h3; req0_c = 2'b00;
        tick();
        chk_rsp("pre_rst", 1'b1, 4'h5, 1'b0);
        req0_valid = 1'b0; rsp_ready = 1'b0; rst = 1'b1;
        tick();
        chk_rsp("mid_rst", 1'b0, 4'h0, 1'b0);
        rst = 1'b0; rsp_ready = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk_rdy("post_rst_tie", 1'b1, 1'b0);
        tick();
        chk("post_rst_id", rsp_id, 1'b0);

        // exhaustive operand/opcode sweep at one op per cycle
        for (int n = 0; n < 1024; n++) begin
            k = n[9:0];
            req0_valid = ~k[0]; req1_valid = k[0];
            req0_a = k[3:0]; req0_b = k[7:4]; req0_c = k[9:8];
            req1_a = k[3:0]; req1_b = k[7:4]; req1_c = k[9:8];
            #1;
            chk_rdy("sweep", ~k[0], k[0]);
            tick();
            chk_rsp("sweep", 1'b1, ref_alu(k[3:0], k[7:4], k[9:8]), k[0]);
        end

        // randomized traffic against a reference model
        req0_valid = 1'b0; req1_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        m_full = 1'b0; m_last = 1'b1; m_f = '0; m_id = 1'b0;
        acc0 = 1'b0; acc1 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!req0_valid || acc0) begin
                req0_valid = 1'($urandom_range(0, 1));
                req0_a = 4'($urandom); req0_b = 4'($urandom); req0_c = 2'($urandom);
            end
            if (!req1_valid || acc1) begin
                req1_valid = 1'($urandom_range(0, 1));
                req1_a = 4'($urandom); req1_b = 4'($urandom); req1_c = 2'($urandom);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            can = !m_full || rsp_ready;
            g0 = req0_valid && (!req1_valid || m_last);
            g1 = req1_valid && (!req0_valid || !m_last);
            e0 = can && g0;
            e1 = can && g1;
            chk_rdy("rand", e0, e1);
            acc0 = e0; acc1 = e1;
            if (e0) begin
                m_f = ref_alu(req0_a, req0_b, req0_c); m_id = 1'b0; m_last = 1'b0; m_full = 1'b1;
            end else if (e1) begin
                m_f = ref_alu(req1_a, req1_b, req1_c); m_id = 1'b1; m_last = 1'b1; m_full = 1'b1;
            end else if (rsp_ready) begin
                m_full = 1'b0;
            end
            tick();
            chk("rand_valid", rsp_valid, m_full);
            if (m_full) begin
                chk("rand_f", rsp_f, m_f);
                chk("rand_id", rsp_id, m_id);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
